// File: rtl/word_serialize.sv
//==============================================================================
// Module      : word_serialize
// Description : Emits the characters of one packed word one per cycle, from a
//               start position up to the first zero char or the last slot.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module word_serialize #(
  parameter int CHAR_BITS    = 7,
  parameter int WORD_MAX_LEN = 8
) (
  input  logic                              CLK,
  input  logic                              rst,
  input  logic [WORD_MAX_LEN*CHAR_BITS-1:0] din,
  input  logic [$clog2(WORD_MAX_LEN)-1:0]   pos,
  input  logic                              wr_en,
  output logic                              full,
  output logic [CHAR_BITS-1:0]              dout,
  output logic                              last,
  input  logic                              rd_en,
  output logic                              empty,
  output logic                              word_empty
);

  localparam int              POS_W    = $clog2(WORD_MAX_LEN);
  localparam logic [POS_W-1:0] c_IDX_LAST = POS_W'(WORD_MAX_LEN - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_OUTPUT = 1'b1
  } state_t;

  state_t                          r_state;
  logic [WORD_MAX_LEN*CHAR_BITS-1:0] r_word;
  logic [POS_W-1:0]                r_idx;
  logic                            r_full;
  logic                            r_empty;
  logic                            r_word_empty;

  logic [CHAR_BITS-1:0] w_din_char  [WORD_MAX_LEN];
  logic [CHAR_BITS-1:0] w_word_char [WORD_MAX_LEN];
  logic [POS_W-1:0]     w_idx_inc;
  logic                 w_pos_oob;
  logic                 w_load_empty;
  logic                 w_last_sel;

  // Char 0 sits in the most significant CHAR_BITS of the packed word.
  for (genvar k = 0; k < WORD_MAX_LEN; k++) begin : g_unpack
    assign w_din_char[k]  = din[(WORD_MAX_LEN-k)*CHAR_BITS-1 -: CHAR_BITS];
    assign w_word_char[k] = r_word[(WORD_MAX_LEN-k)*CHAR_BITS-1 -: CHAR_BITS];
  end

  // A start position past the last slot is only representable when the
  // word length is not a power of two.
  if ((2 ** POS_W) > WORD_MAX_LEN) begin : g_pos_chk
    assign w_pos_oob = ({1'b0, pos} > {1'b0, c_IDX_LAST});
  end else begin : g_pos_full
    assign w_pos_oob = 1'b0;
  end

  assign w_load_empty = w_pos_oob || (w_din_char[pos] == '0);
  assign w_idx_inc    = r_idx + POS_W'(1);
  assign w_last_sel   = (r_idx == c_IDX_LAST) || (w_word_char[w_idx_inc] == '0);

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_word       <= '0;
      r_idx        <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_word_empty <= 1'b0;
    end else begin
      r_word_empty <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wr_en) begin
            r_word <= din;
            r_idx  <= w_pos_oob ? '0 : pos;
            if (w_load_empty) begin
              r_word_empty <= 1'b1;
            end else begin
              r_state <= S_OUTPUT;
              r_full  <= 1'b1;
              r_empty <= 1'b0;
            end
          end
        end
        S_OUTPUT: begin
          if (rd_en) begin
            if (w_last_sel) begin
              r_state <= S_IDLE;
              r_full  <= 1'b0;
              r_empty <= 1'b1;
            end else begin
              r_idx <= w_idx_inc;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_full  <= 1'b0;
          r_empty <= 1'b1;
        end
      endcase
    end
  end

  assign full       = r_full;
  assign empty      = r_empty;
  assign word_empty = r_word_empty;
  assign dout       = (r_state == S_OUTPUT) ? w_word_char[r_idx] : '0;
  assign last       = (r_state == S_OUTPUT) && w_last_sel;

endmodule

`default_nettype wire
